// File: rtl/cl_word_unpacker.sv
// Cache-line to word unpacker: pops whole lines from a FWFT DMA read FIFO and
// streams them out one word at a time over valid/ready, refilling without a bubble.
module cl_word_unpacker #(
    parameter int CL_WIDTH   = 512,
    parameter int WORD_WIDTH = 32,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE_WIDTH-1:0] size,
    input  logic                  dma_empty,
    input  logic [CL_WIDTH-1:0]   dma_rd_data,
    output logic                  dma_rd_en,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    // CL_WIDTH is expected to be an integer multiple of WORD_WIDTH.
    localparam int WPL   = CL_WIDTH / WORD_WIDTH;
    localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [CL_WIDTH-1:0]   r_line_buf;
    logic [IDX_W-1:0]      r_word_idx;
    logic [SIZE_WIDTH-1:0] r_lines_left;

    logic [WORD_WIDTH-1:0] w_words [WPL];
    logic                  w_in_fetch;
    logic                  w_in_drain;
    logic                  w_last_word;
    logic                  w_more_lines;
    logic                  w_handshake;
    logic                  w_refill;
    logic                  w_fetch_pop;
    logic                  w_pop;

    for (genvar g = 0; g < WPL; g++) begin : g_words
        assign w_words[g] = r_line_buf[g*WORD_WIDTH +: WORD_WIDTH];
    end

    assign w_in_fetch   = (r_state == S_FETCH);
    assign w_in_drain   = (r_state == S_DRAIN);
    assign w_last_word  = (r_word_idx == IDX_W'(WPL - 1));
    assign w_more_lines = (r_lines_left != '0);
    assign w_handshake  = w_in_drain && word_ready;

    // Refill on the final-word handshake so the next line follows with no gap.
    assign w_refill     = w_handshake && w_last_word && w_more_lines && !dma_empty;
    assign w_fetch_pop  = w_in_fetch && !dma_empty;
    assign w_pop        = w_fetch_pop || w_refill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_line_buf   <= '0;
            r_word_idx   <= '0;
            r_lines_left <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (size != '0) begin
                            r_lines_left <= size;
                            r_state      <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    if (!dma_empty) begin
                        r_line_buf   <= dma_rd_data;
                        r_word_idx   <= '0;
                        r_lines_left <= r_lines_left - 1'b1;
                        r_state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (word_ready) begin
                        if (!w_last_word) begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end else if (!w_more_lines) begin
                            r_state <= S_DONE;
                        end else if (!dma_empty) begin
                            r_line_buf   <= dma_rd_data;
                            r_word_idx   <= '0;
                            r_lines_left <= r_lines_left - 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Valid/ready: a word transfers on a cycle with word_valid && word_ready;
    // while valid is high and not accepted, word_data and word_last hold.
    assign dma_rd_en  = w_pop;
    assign word_valid = w_in_drain;
    assign word_data  = w_in_drain ? w_words[r_word_idx] : '0;
    assign word_last  = w_in_drain && w_last_word && !w_more_lines;
    assign busy       = w_in_fetch || w_in_drain;
    assign done       = (r_state == S_DONE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_cl_word_unpacker.sv
// Scoreboard bench for cl_word_unpacker: FWFT DMA model, expected-word queue,
// directed scenarios plus one randomized ready/stall run.
module tb_cl_word_unpacker;

    localparam int CLW = 512;
    localparam int WW  = 32;
    localparam int SW  = 16;
    localparam int WPL = CLW / WW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [SW-1:0]  size = '0;
    logic           dma_empty = 1'b1;
    logic [CLW-1:0] dma_rd_data = '0;
    logic           dma_rd_en;
    logic           word_valid;
    logic           word_ready = 1'b1;
    logic [WW-1:0]  word_data;
    logic           word_last;
    logic           busy;
    logic           done;
    logic [1:0]     dbg_state;

    cl_word_unpacker #(.CL_WIDTH(CLW), .WORD_WIDTH(WW), .SIZE_WIDTH(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .size        (size),
        .dma_empty   (dma_empty),
        .dma_rd_data (dma_rd_data),
        .dma_rd_en   (dma_rd_en),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_last   (word_last),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    logic [WW:0]    exp_q[$];
    logic [CLW-1:0] dma_q[$];
    int             pop_cyc[$];
    int             n_checks = 0;
    int             n_pass = 0;
    int             pops = 0;
    int             hs_cnt = 0;
    int             cyc = 0;
    int             ready_mode = 0;
    int             rcnt = 0;
    bit             pend_pop = 0;
    bit             dma_stall = 0;
    bit             stall_mode = 0;
    bit             gap_chk = 0;
    bit             seen_valid = 0;
    bit             done_pending = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic void update_dma();
        dma_empty   = dma_stall || (dma_q.size() == 0);
        dma_rd_data = (dma_q.size() > 0) ? dma_q[0] : '0;
    endfunction

    function automatic logic [CLW-1:0] make_line(input logic [WW-1:0] base);
        logic [CLW-1:0] l;
        l = '0;
        for (int k = 0; k < WPL; k++) l[k*WW +: WW] = base + WW'(k);
        return l;
    endfunction

    // Loads n_in_dma lines into the DMA model and queues all n_lines worth of words.
    task automatic push_xfer(input int n_lines, input logic [WW-1:0] base, input int n_in_dma);
        logic lst;
        for (int l = 0; l < n_lines; l++) begin
            if (l < n_in_dma) dma_q.push_back(make_line(base + WW'(l * WPL)));
            for (int k = 0; k < WPL; k++) begin
                lst = (l == n_lines - 1) && (k == WPL - 1);
                exp_q.push_back({lst, base + WW'(l * WPL + k)});
            end
        end
        update_dma();
    endtask

    task automatic start_xfer(input logic [SW-1:0] s);
        pops = 0;
        hs_cnt = 0;
        seen_valid = 0;
        pop_cyc.delete();
        @(posedge clk); #1;
        start = 1'b1;
        size  = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_hs(input int n, input int budget);
        int t;
        t = 0;
        while (hs_cnt < n && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq("hs_timeout", (hs_cnt >= n), 1);
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!(done && exp_q.size() == 0) && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq("done_timeout", (t < budget), 1);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL watchdog got=%0d exp=<60000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    // DMA model: a pop seen before the edge removes the head line just after it.
    always @(posedge clk) begin
        #1;
        if (pend_pop) begin
            if (dma_q.size() > 0) void'(dma_q.pop_front());
            pend_pop = 0;
        end
        case (ready_mode)
            0: word_ready = 1'b1;
            1: word_ready = (rcnt % 3 == 0);
            default: word_ready = 1'($urandom_range(0, 1));
        endcase
        rcnt++;
        if (stall_mode) dma_stall = ($urandom_range(0, 3) == 0);
        update_dma();
    end

    always @(negedge clk) begin
        logic [WW:0] head;
        if (!rst) begin
            if (done_pending) begin
                check_eq("done_after_last", done, 1);
                check_eq("busy_after_last", busy, 0);
                done_pending = 0;
            end
            if (dma_rd_en) begin
                check_eq("rd_en_while_empty", dma_empty, 0);
                pops++;
                pop_cyc.push_back(cyc);
                pend_pop = 1;
            end
            if (gap_chk && seen_valid && exp_q.size() > 0) check_eq("valid_gap", word_valid, 1);
            if (word_valid) begin
                seen_valid = 1;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", word_valid, 0);
                end else begin
                    head = exp_q[0];
                    check_eq("word_data", word_data, head[WW-1:0]);
                    check_eq("word_last", word_last, head[WW]);
                    if (word_ready) begin
                        hs_cnt++;
                        if (head[WW]) done_pending = 1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        update_dma();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_rd_en", dma_rd_en, 0);
        check_eq("rst_valid", word_valid, 0);
        check_eq("rst_last", word_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_data", word_data, 0);
        check_eq("rst_state", dbg_state, 0);

        // Zero-size transfer from IDLE
        start_xfer(0);
        @(negedge clk);
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        check_eq("zero_valid", word_valid, 0);
        repeat (3) @(negedge clk);
        check_eq("zero_pops", pops, 0);

        // Single line, latency check
        push_xfer(1, 32'h0, 1);
        start_xfer(1);
        @(negedge clk);
        check_eq("lat_fetch_state", dbg_state, 1);
        check_eq("lat_fetch_valid", word_valid, 0);
        check_eq("start_clears_done", done, 0);
        check_eq("lat_busy", busy, 1);
        @(negedge clk);
        check_eq("lat_valid", word_valid, 1);
        wait_done(200);
        check_eq("single_pops", pops, 1);
        check_eq("single_hs", hs_cnt, 16);

        // Back-to-back lines with no bubble
        gap_chk = 1;
        push_xfer(3, 32'h100, 3);
        start_xfer(3);
        wait_done(300);
        gap_chk = 0;
        check_eq("b2b_pops", pops, 3);
        check_eq("b2b_hs", hs_cnt, 48);
        if (pop_cyc.size() == 3) begin
            check_eq("b2b_pop_gap1", pop_cyc[1] - pop_cyc[0], 16);
            check_eq("b2b_pop_gap2", pop_cyc[2] - pop_cyc[1], 16);
        end else begin
            check_eq("b2b_pop_count", pop_cyc.size(), 3);
        end

        // Backpressure 1,0,0 pattern
        ready_mode = 1;
        push_xfer(1, 32'h200, 1);
        start_xfer(1);
        wait_done(300);
        ready_mode = 0;
        check_eq("bp_pops", pops, 1);
        check_eq("bp_hs", hs_cnt, 16);

        // DMA starvation between lines
        push_xfer(2, 32'h300, 1);
        start_xfer(2);
        wait_hs(16, 200);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("starve_state", dbg_state, 1);
            check_eq("starve_valid", word_valid, 0);
            check_eq("starve_rd_en", dma_rd_en, 0);
        end
        @(posedge clk); #1;
        dma_q.push_back(make_line(32'h310));
        update_dma();
        wait_done(200);
        check_eq("starve_pops", pops, 2);
        check_eq("starve_hs", hs_cnt, 32);

        // start while busy is ignored
        push_xfer(1, 32'h400, 1);
        start_xfer(1);
        wait_hs(3, 100);
        @(posedge clk); #1;
        start = 1'b1;
        size  = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        repeat (20) @(negedge clk);
        check_eq("busy_start_hs", hs_cnt, 16);
        check_eq("busy_start_pops", pops, 1);
        check_eq("busy_start_done", done, 1);

        // Reset mid-transfer
        push_xfer(2, 32'h500, 2);
        start_xfer(2);
        wait_hs(7, 100);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_rd_en", dma_rd_en, 0);
        check_eq("mid_rst_valid", word_valid, 0);
        check_eq("mid_rst_last", word_last, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_data", word_data, 0);
        check_eq("mid_rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        dma_q.delete();
        pend_pop = 0;
        done_pending = 0;
        update_dma();
        push_xfer(1, 32'h600, 1);
        start_xfer(1);
        wait_done(200);
        check_eq("post_rst_pops", pops, 1);
        check_eq("post_rst_hs", hs_cnt, 16);

        // Random ready and DMA stalls
        ready_mode = 2;
        stall_mode = 1;
        push_xfer(3, 32'h700, 3);
        start_xfer(3);
        wait_done(3000);
        stall_mode = 0;
        ready_mode = 0;
        @(posedge clk); #1;
        dma_stall = 0;
        update_dma();
        check_eq("rand_pops", pops, 3);
        check_eq("rand_hs", hs_cnt, 48);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
